register_file_mp: RTL and testbench

//  Parametrised multi-read-port CPU register file; next-generation register store for the Retro16 core.
//  - Register 0 is hardwired to zero; register PC_INDEX doubles as program counter with increment/load.
//  - Write-through bypass to all read ports.
//  - Signed condition flags (Z,P,N) taken from the value actually written.
//  - Per-register busy scoreboard so the issue stage can stall on pending long-latency writes.

---
 rtl/register_file_mp_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 31 +++
 rtl/register_file_mp.sv | 115 +++++++++++
 tb/tb_register_file_mp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// rtl/register_file_mp_pkg.sv - shared constants and types for the Retro16 register file
package register_file_mp_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int REG_ZERO   = 0;
    localparam int REG_PC     = 6;

    localparam int COND_Z = 2;
    localparam int COND_P = 1;
    localparam int COND_N = 0;

    localparam logic [2:0] COND_RESET = 3'b100;

    typedef logic [2:0] cond_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy vector, set wins over clear, register 0 never busy
module reg_scoreboard #(
    parameter  int NUM_REGS = 8,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_set,
    input  logic [AW-1:0]       i_set_num,
    input  logic                i_clr,
    input  logic [AW-1:0]       i_clr_num,
    output logic [NUM_REGS-1:0] o_busy_next
);

    logic [NUM_REGS-1:0] r_busy;

    always_comb begin
        o_busy_next = r_busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (i_clr && i_clr_num == AW'(r)) o_busy_next[r] = 1'b0;
            if (i_set && i_set_num == AW'(r)) o_busy_next[r] = 1'b1;
        end
        o_busy_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_busy <= '0;
        else       r_busy <= o_busy_next;
    end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-read-port register file with zero register, PC, bypass, flags
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = 8,
    parameter  int NUM_RD   = 2,
    parameter  int PC_INDEX = REG_PC,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_RD*AW-1:0]     i_rd_num,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic                     i_wr_en,
    input  logic [AW-1:0]            i_wr_num,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_wr_flags_en,
    output logic [2:0]               o_cond_out,
    input  logic                     i_pc_inc,
    input  logic                     i_pc_load,
    input  logic [DATA_W-1:0]        i_pc_load_val,
    output logic [DATA_W-1:0]        o_pc_out,
    input  logic                     i_busy_set,
    input  logic [AW-1:0]            i_busy_num
);

    localparam logic [AW-1:0] PC_A = AW'(PC_INDEX);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   w_next [NUM_REGS];
    logic [DATA_W-1:0]   w_rd_val [NUM_RD];
    logic [NUM_RD-1:0]   w_rd_bsy;
    logic [DATA_W-1:0]   w_pc_next;
    logic [NUM_REGS-1:0] w_busy_next;
    logic                w_wr_ok;
    logic                w_wr_zero;
    cond_t               w_cond_new;
    cond_t               r_cond;

    assign w_wr_ok = i_wr_en && (i_wr_num != '0);

    always_comb begin
        w_pc_next = r_regs[PC_INDEX];
        if (i_pc_load)                          w_pc_next = i_pc_load_val;
        else if (w_wr_ok && i_wr_num == PC_A)   w_pc_next = i_wr_data;
        else if (i_pc_inc)                      w_pc_next = r_regs[PC_INDEX] + DATA_W'(1);
    end

    // w_next is the post-edge register image; reads return it, which gives the bypass for free
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_next[r] = r_regs[r];
            if (w_wr_ok && i_wr_num == AW'(r)) w_next[r] = i_wr_data;
        end
        w_next[PC_INDEX] = w_pc_next;
        w_next[0]        = '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= w_next[r];
        end
    end

    assign w_wr_zero = (i_wr_data == '0);

    always_comb begin
        w_cond_new         = '0;
        w_cond_new[COND_Z] = w_wr_zero;
        w_cond_new[COND_N] = i_wr_data[DATA_W-1];
        w_cond_new[COND_P] = !w_wr_zero && !i_wr_data[DATA_W-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)                          r_cond <= COND_RESET;
        else if (w_wr_ok && i_wr_flags_en)  r_cond <= w_cond_new;
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_set       (i_busy_set),
        .i_set_num   (i_busy_num),
        .i_clr       (i_wr_en),
        .i_clr_num   (i_wr_num),
        .o_busy_next (w_busy_next)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr      = i_rd_num[k*AW +: AW];
        assign w_rd_val[k] = w_next[w_addr];
        assign w_rd_bsy[k] = w_busy_next[w_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data <= '0;
            o_rd_busy <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) o_rd_data[k*DATA_W +: DATA_W] <= w_rd_val[k];
            o_rd_busy <= w_rd_bsy;
        end
    end

    assign o_cond_out = r_cond;
    assign o_pc_out   = r_regs[PC_INDEX];

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - scoreboard bench for register_file_mp with directed vectors
module tb_register_file_mp;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [2*AW-1:0] rd_num;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic          wr_en;
    logic [AW-1:0] wr_num;
    logic [DW-1:0] wr_data;
    logic          wr_flags_en;
    logic [2:0]    cond_out;
    logic          pc_inc;
    logic          pc_load;
    logic [DW-1:0] pc_load_val;
    logic [DW-1:0] pc_out;
    logic          busy_set;
    logic [AW-1:0] busy_num;

    always #5 clk = ~clk;

    register_file_mp dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rd_num      (rd_num),
        .o_rd_data     (rd_data),
        .o_rd_busy     (rd_busy),
        .i_wr_en       (wr_en),
        .i_wr_num      (wr_num),
        .i_wr_data     (wr_data),
        .i_wr_flags_en (wr_flags_en),
        .o_cond_out    (cond_out),
        .i_pc_inc      (pc_inc),
        .i_pc_load     (pc_load),
        .i_pc_load_val (pc_load_val),
        .o_pc_out      (pc_out),
        .i_busy_set    (busy_set),
        .i_busy_num    (busy_num)
    );

    typedef struct {
        int          due;
        string       nm;
        logic [3:0]  m;
        logic [31:0] rd;
        logic [1:0]  b;
        logic [2:0]  c;
        logic [15:0] pc;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.m[3]) begin
                checks++;
                if (rd_data !== e.rd) begin
                    errors++;
                    $display("FAIL %s rd_data got=%h exp=%h", e.nm, rd_data, e.rd);
                end
            end
            if (e.m[2]) begin
                checks++;
                if (rd_busy !== e.b) begin
                    errors++;
                    $display("FAIL %s rd_busy got=%b exp=%b", e.nm, rd_busy, e.b);
                end
            end
            if (e.m[1]) begin
                checks++;
                if (cond_out !== e.c) begin
                    errors++;
                    $display("FAIL %s cond_out got=%b exp=%b", e.nm, cond_out, e.c);
                end
            end
            if (e.m[0]) begin
                checks++;
                if (pc_out !== e.pc) begin
                    errors++;
                    $display("FAIL %s pc_out got=%h exp=%h", e.nm, pc_out, e.pc);
                end
            end
        end
    end

    task automatic idle();
        rst = 1'b0; rd_num = '0; wr_en = 1'b0; wr_num = '0; wr_data = '0;
        wr_flags_en = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; pc_load_val = '0;
        busy_set = 1'b0; busy_num = '0;
    endtask

    task automatic rdp(input int p0, input int p1);
        rd_num = {AW'(p1), AW'(p0)};
    endtask

    task automatic wr(input int n, input logic [15:0] d, input logic fl);
        wr_en = 1'b1; wr_num = AW'(n); wr_data = d; wr_flags_en = fl;
    endtask

    // expected values describe outputs right after the next rising edge
    task automatic go(input string nm, input logic [31:0] erd, input logic [1:0] eb,
                      input logic [2:0] ec, input logic [15:0] epc);
        exp_t e;
        e.due = cyc + 1; e.nm = nm; e.m = 4'b1111;
        e.rd = erd; e.b = eb; e.c = ec; e.pc = epc;
        q.push_back(e);
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        go("reset", 32'h0, 2'b00, 3'b100, 16'h0);

        wr(3, 16'h8001, 1'b1); rdp(3, 0);
        go("wr_r3_bypass", {16'h0000, 16'h8001}, 2'b00, 3'b001, 16'h0);
        rdp(3, 3);
        go("rd_r3", {16'h8001, 16'h8001}, 2'b00, 3'b001, 16'h0);
        wr(0, 16'h1234, 1'b1); rdp(0, 3);
        go("wr_r0_discard", {16'h8001, 16'h0000}, 2'b00, 3'b001, 16'h0);
        wr(5, 16'h00AA, 1'b0); rdp(5, 5);
        go("bypass_both", {16'h00AA, 16'h00AA}, 2'b00, 3'b001, 16'h0);
        wr(1, 16'h0005, 1'b1); rdp(1, 5);
        go("flag_p", {16'h00AA, 16'h0005}, 2'b00, 3'b010, 16'h0);
        wr(1, 16'h0000, 1'b1); rdp(1, 1);
        go("flag_z", {16'h0000, 16'h0000}, 2'b00, 3'b100, 16'h0);

        wr(6, 16'hFFFF, 1'b0); rdp(6, 0);
        go("wr_pc", {16'h0000, 16'hFFFF}, 2'b00, 3'b100, 16'hFFFF);
        pc_inc = 1'b1; rdp(6, 5);
        go("pc_wrap", {16'h00AA, 16'h0000}, 2'b00, 3'b100, 16'h0000);
        pc_load = 1'b1; pc_load_val = 16'h0040; wr(6, 16'h0010, 1'b0); pc_inc = 1'b1; rdp(6, 0);
        go("pc_priority", {16'h0000, 16'h0040}, 2'b00, 3'b100, 16'h0040);
        rdp(6, 6);
        go("pc_hold", {16'h0040, 16'h0040}, 2'b00, 3'b100, 16'h0040);
        pc_inc = 1'b1; rdp(6, 0);
        go("pc_inc", {16'h0000, 16'h0041}, 2'b00, 3'b100, 16'h0041);

        busy_set = 1'b1; busy_num = 3'd2; rdp(2, 0);
        go("busy_set_r2", {16'h0000, 16'h0000}, 2'b01, 3'b100, 16'h0041);
        rdp(2, 2);
        go("busy_hold_r2", {16'h0000, 16'h0000}, 2'b11, 3'b100, 16'h0041);
        wr(2, 16'h1111, 1'b0); busy_set = 1'b1; busy_num = 3'd2; rdp(2, 0);
        go("set_wins", {16'h0000, 16'h1111}, 2'b01, 3'b100, 16'h0041);
        wr(2, 16'h2222, 1'b0); rdp(2, 2);
        go("busy_clear", {16'h2222, 16'h2222}, 2'b00, 3'b100, 16'h0041);
        busy_set = 1'b1; busy_num = 3'd0; rdp(0, 0);
        go("busy_r0", {16'h0000, 16'h0000}, 2'b00, 3'b100, 16'h0041);
        busy_set = 1'b1; busy_num = 3'd4; rdp(4, 0);
        go("busy_set_r4", {16'h0000, 16'h0000}, 2'b01, 3'b100, 16'h0041);
        rst = 1'b1; wr(4, 16'h7777, 1'b1); rdp(4, 4);
        go("rst_mid_op", {16'h0000, 16'h0000}, 2'b00, 3'b100, 16'h0000);
        rdp(4, 4);
        go("after_rst_r4", {16'h0000, 16'h0000}, 2'b00, 3'b100, 16'h0000);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #6;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
